cache_mem_responder: RTL and testbench

- Pipelined multi-cycle main-memory responder serving the I-cache and D-cache fill/writeback FSMs of the 16-bit pipelined CPU.
- Accepts at most one word request per cycle from two initiator ports, D-port first, with an anti-starvation guard for the I-port.
- Returns read data exactly LATENCY cycles after acceptance, tagged to the requesting port.

---
 rtl/cache_mem_responder_pkg.sv | 27 ++
 rtl/cache_mem_responder_rsp_pipe.sv | 56 +++++
 rtl/cache_mem_responder.sv | 158 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_mem_responder_pkg                                         |
// | Purpose  : Shared constants and types for the cache main-memory responder. |
// |            Holds the default address/data widths, the port-tag encoding   |
// |            carried with every read through the response pipeline, and the |
// |            pipeline stage record.                                         |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package cache_mem_responder_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  // Tag stored with each in-flight read to steer it back to its initiator.
  localparam logic PORT_D = 1'b1;
  localparam logic PORT_I = 1'b0;

  // One stage of the read-response shift pipeline.
  typedef struct packed {
    logic                  valid;
    logic                  tag;
    logic [MEM_DATA_W-1:0] data;
  } rsp_stage_t;

endpackage : cache_mem_responder_pkg
`default_nettype wire

// File: rtl/cache_mem_responder_rsp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_rsp_pipe                                                    |
// | Purpose  : LATENCY-deep shift register carrying {valid, tag, data} for    |
// |            each accepted read. A read entering at an edge appears on the  |
// |            outputs LATENCY cycles later. Synchronous active-low clear     |
// |            drops everything in flight.                                    |
// | Ports    : clk, rst_n        - clock, synchronous active-low clear        |
// |            valid_i/tag_i/data_i - stage-0 input (sampled every edge)     |
// |            valid_o/tag_o/data_o - last-stage registered outputs          |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module mem_rsp_pipe
  import cache_mem_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  tag_i,
  input  logic [MEM_DATA_W-1:0] data_i,
  output logic                  valid_o,
  output logic                  tag_o,
  output logic [MEM_DATA_W-1:0] data_o
);

  rsp_stage_t stage_d;
  rsp_stage_t stage_q [LATENCY];

  always_comb begin
    stage_d       = '0;
    stage_d.valid = valid_i;
    stage_d.tag   = tag_i;
    stage_d.data  = data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= stage_d;
      for (int k = 1; k < LATENCY; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign valid_o = stage_q[LATENCY-1].valid;
  assign tag_o   = stage_q[LATENCY-1].tag;
  assign data_o  = stage_q[LATENCY-1].data;

endmodule : mem_rsp_pipe
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_mem_responder                                             |
// | Purpose  : Pipelined main-memory responder for the I- and D-cache fill /  |
// |            writeback engines. One word request accepted per cycle, D     |
// |            port preferred, I port forced through after STARVE_LIM         |
// |            consecutive denials. Reads return LATENCY cycles after accept. |
// | Ports    : clk, rst_n (sync, active-low)                                  |
// |            d_req/d_wr/d_addr/d_wdata -> d_gnt   (D initiator)             |
// |            i_req/i_addr              -> i_gnt   (I initiator, read only)  |
// |            rdata, d_rvalid, i_rvalid            (registered response)     |
// |            rd_count, wr_count, i_stall_count    (only with MEM_STATS_EN)  |
// | Config   : define MEM_STATS_EN to add saturating activity counters.       |
// | Note     : DATA_W must equal MEM_DATA_W (response pipeline record width). |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int MEM_WORDS_LOG2 = 15,
  parameter int LATENCY        = 4,
  parameter int STARVE_LIM     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              d_rvalid,
  output logic              i_rvalid
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       i_stall_count
`endif
);

  localparam int CNT_W     = ($clog2(STARVE_LIM + 1) > 2) ? $clog2(STARVE_LIM + 1) : 2;
  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0]          starve_q;
  logic [CNT_W-1:0]          starve_d;
  logic [DATA_W-1:0]         mem_q [MEM_WORDS];

  logic [MEM_WORDS_LOG2-1:0] w_d_idx;
  logic [MEM_WORDS_LOG2-1:0] w_i_idx;
  logic [MEM_WORDS_LOG2-1:0] w_rd_idx;
  logic                      w_rd_en;
  logic                      w_rd_tag;
  logic [DATA_W-1:0]         w_rd_data;
  logic                      w_pipe_valid;
  logic                      w_pipe_tag;
  logic                      w_unused;

  // Byte addresses: bit 0 and everything above the array index are dropped,
  // so addresses wrap modulo the array size.
  assign w_d_idx  = d_addr[MEM_WORDS_LOG2:1];
  assign w_i_idx  = i_addr[MEM_WORDS_LOG2:1];
  assign w_unused = ^{d_addr, i_addr};

  // Arbiter: D wins a tie unless I has been turned away STARVE_LIM times in a row.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (rst_n) begin
      if (d_req && !(i_req && (starve_q == STARVE_MAX))) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (i_req && !i_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Backing array: not reset. Only one grant per cycle, so a write and a read
  // never collide on the same edge.
  always_ff @(posedge clk) begin
    if (d_gnt && d_wr) begin
      mem_q[w_d_idx] <= d_wdata;
    end
  end

  assign w_rd_en   = (d_gnt && !d_wr) || i_gnt;
  assign w_rd_tag  = d_gnt ? PORT_D : PORT_I;
  assign w_rd_idx  = d_gnt ? w_d_idx : w_i_idx;
  // Array contents are sampled at the accept edge into pipeline stage 0.
  assign w_rd_data = w_rd_en ? mem_q[w_rd_idx] : '0;

  mem_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (w_rd_en),
    .tag_i   (w_rd_tag),
    .data_i  (w_rd_data),
    .valid_o (w_pipe_valid),
    .tag_o   (w_pipe_tag),
    .data_o  (rdata)
  );

  assign d_rvalid = w_pipe_valid && (w_pipe_tag == PORT_D);
  assign i_rvalid = w_pipe_valid && (w_pipe_tag == PORT_I);

`ifdef MEM_STATS_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;
  logic [31:0] i_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      i_stall_q  <= '0;
    end else begin
      if (w_rd_en && (rd_count_q != 32'hFFFF_FFFF)) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (d_gnt && d_wr && (wr_count_q != 32'hFFFF_FFFF)) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
      if (i_req && !i_gnt && (i_stall_q != 32'hFFFF_FFFF)) begin
        i_stall_q <= i_stall_q + 32'd1;
      end
    end
  end

  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;
  assign i_stall_count = i_stall_q;
`endif

endmodule : cache_mem_responder
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_mem_responder                                          |
// | Purpose  : Scoreboard bench. A driver keeps per-port request queues,      |
// |            decides grants from the arbitration rules, updates a word-    |
// |            array model and pushes expected responses; a monitor pops and |
// |            compares them whenever the DUT raises d_rvalid / i_rvalid.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_cache_mem_responder;

  localparam int LAT    = 4;
  localparam int STARVE = 3;
  localparam int WORDS  = 1 << 15;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic        tag;    // 1 = D, 0 = I
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        d_req, d_wr, d_gnt;
  logic [15:0] d_addr, d_wdata;
  logic        i_req, i_gnt;
  logic [15:0] i_addr;
  logic [15:0] rdata;
  logic        d_rvalid, i_rvalid;
`ifdef MEM_STATS_EN
  logic [31:0] rd_count, wr_count, i_stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  req_t        dq[$];
  req_t        iq[$];
  exp_t        expq[$];
  logic [1:0]  glog[$];
  logic [15:0] mem_m [int];
  bit          d_act = 0, i_act = 0, rnd_mode = 0, rec = 0;
  int          deny_run = 0;
  int          rd_m = 0, wr_m = 0, st_m = 0;

  cache_mem_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .rdata    (rdata),
    .d_rvalid (d_rvalid),
    .i_rvalid (i_rvalid)
`ifdef MEM_STATS_EN
    ,
    .rd_count      (rd_count),
    .wr_count      (wr_count),
    .i_stall_count (i_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [15:0] a);
    return int'(a >> 1) % WORDS;
  endfunction

  function automatic logic [15:0] pool_addr();
    int w;
    logic [15:0] a;
    w = ($urandom_range(1) != 0) ? int'($urandom_range(31)) : 32760 + int'($urandom_range(7));
    a = 16'(w << 1) | 16'($urandom_range(1));
    return a;
  endfunction

  function automatic req_t mk(input logic wr, input logic [15:0] a, input logic [15:0] dat);
    req_t r;
    r.wr = wr; r.addr = a; r.data = dat;
    return r;
  endfunction

  // Monitor: compare each presented response against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (d_rvalid || i_rvalid) begin
      checks++;
      if (d_rvalid && i_rvalid) begin
        errors++;
        $display("FAIL rvalid_exclusive: d_rvalid=1 i_rvalid=1 at cycle %0d, want at most one", cyc);
      end else if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rvalid d=%0b i=%0b data=%h at cycle %0d, want none", d_rvalid, i_rvalid, rdata, cyc);
      end else begin
        e = expq.pop_front();
        if (d_rvalid !== e.tag || rdata !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rsp: got tag_d=%0b data=%h cycle=%0d, want tag_d=%0b data=%h cycle=%0d",
                   d_rvalid, rdata, cyc, e.tag, e.data, e.due);
        end
      end
    end else if (expq.size() > 0 && expq[0].due < cyc) begin
      checks++;
      errors++;
      e = expq.pop_front();
      $display("FAIL missing_rsp: no rvalid by cycle %0d, want tag_d=%0b data=%h at cycle %0d", cyc, e.tag, e.data, e.due);
    end
  end

  // One bus cycle: present held/new requests, then at the falling edge decide
  // the grants from the rules, compare, and advance the model.
  task automatic step();
    req_t hd, hi;
    exp_t e;
    bit   gd, gi;
    if (!d_act && dq.size() > 0 && (!rnd_mode || $urandom_range(3) != 0)) d_act = 1;
    if (!i_act && iq.size() > 0 && (!rnd_mode || $urandom_range(3) != 0)) i_act = 1;
    if (d_act) begin
      hd = dq[0];
      d_req = 1'b1; d_wr = hd.wr; d_addr = hd.addr; d_wdata = hd.data;
    end else begin
      d_req = 1'b0; d_wr = 1'($urandom_range(1)); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    if (i_act) begin
      hi = iq[0];
      i_req = 1'b1; i_addr = hi.addr;
    end else begin
      i_req = 1'b0; i_addr = 16'($urandom);
    end
    @(negedge clk);
    gd = 0; gi = 0;
    if (rst_n) begin
      // I is forced through once it has been turned away STARVE times running.
      if (i_act && deny_run >= STARVE) gi = 1;
      else if (d_act) gd = 1;
      else if (i_act) gi = 1;
    end
    checks++;
    if (d_gnt !== gd || i_gnt !== gi) begin
      errors++;
      $display("FAIL grant: got d_gnt=%0b i_gnt=%0b at cycle %0d, want d_gnt=%0b i_gnt=%0b", d_gnt, i_gnt, cyc, gd, gi);
    end
    if (rec) glog.push_back({d_gnt, i_gnt});
    if (gd) begin
      if (hd.wr) begin
        mem_m[widx(hd.addr)] = hd.data;
        wr_m++;
      end else begin
        e.tag = 1'b1; e.data = mem_m[widx(hd.addr)]; e.due = cyc + LAT;
        expq.push_back(e);
        rd_m++;
      end
      void'(dq.pop_front());
      d_act = 0;
    end
    if (gi) begin
      e.tag = 1'b0; e.data = mem_m[widx(hi.addr)]; e.due = cyc + LAT;
      expq.push_back(e);
      rd_m++;
      void'(iq.pop_front());
      i_act = 0;
    end
    if (i_act && !gi && rst_n) begin
      deny_run = (deny_run < STARVE) ? deny_run + 1 : STARVE;
      st_m++;
    end else begin
      deny_run = 0;
    end
    if (!rst_n) begin
      rd_m = 0; wr_m = 0; st_m = 0;
      #1;
      expq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int limit);
    int n;
    n = 0;
    while ((d_act || i_act || dq.size() > 0 || iq.size() > 0) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (d_act || i_act || dq.size() > 0 || iq.size() > 0) begin
      errors++;
      $display("FAIL timeout: %0d D and %0d I requests left after %0d cycles, want 0", dq.size(), iq.size(), limit);
      dq.delete(); iq.delete(); d_act = 0; i_act = 0;
    end
    repeat (LAT + 2) step();
  endtask

  initial begin
    logic [1:0] pat [8];
    pat = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    rst_n = 1'b0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; i_req = 0; i_addr = 0;
    @(posedge clk); #1;

    // Reset with both ports requesting: grants must stay low.
    dq.push_back(mk(1'b1, 16'h0000, 16'h1111));
    iq.push_back(mk(1'b0, 16'h0001, 16'h0000));
    repeat (3) step();
    rst_n = 1'b1;
    checks++;
    if (rdata !== 16'h0 || d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got rdata=%h d_rvalid=%0b i_rvalid=%0b, want 0000 0 0", rdata, d_rvalid, i_rvalid);
    end
    run_until_empty(20);

    // Preload the address pool.
    for (int w = 0; w < 32; w++) begin
      logic [15:0] v;
      v = (w < 4) ? 16'(16'h1111 * (w + 1)) : (w == 16) ? 16'h0000 : 16'($urandom);
      dq.push_back(mk(1'b1, 16'(w << 1), v));
    end
    for (int w = 32760; w < 32768; w++) dq.push_back(mk(1'b1, 16'(w << 1), 16'($urandom)));
    run_until_empty(100);

    // D write then read back.
    dq.push_back(mk(1'b1, 16'h0010, 16'hBEEF));
    dq.push_back(mk(1'b0, 16'h0010, 16'h0000));
    run_until_empty(20);

    // I burst of four consecutive reads.
    for (int k = 0; k < 4; k++) iq.push_back(mk(1'b0, 16'(k * 2), 16'h0000));
    run_until_empty(20);

    // Both ports held: D,D,D,I,D,D,D,I.
    rec = 1;
    for (int k = 0; k < 6; k++) dq.push_back(mk(1'b0, 16'(k * 2), 16'h0000));
    iq.push_back(mk(1'b0, 16'h0002, 16'h0000));
    iq.push_back(mk(1'b0, 16'h0004, 16'h0000));
    run_until_empty(30);
    rec = 0;
    checks++;
    if (glog.size() < 8) begin
      errors++;
      $display("FAIL grant_pattern: got %0d logged grants, want 8", glog.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (glog[k] !== pat[k]) begin
          errors++;
          $display("FAIL grant_pattern: slot %0d got {d,i}=%b, want %b", k, glog[k], pat[k]);
        end
      end
    end

    // Read-before-write and read-after-write on the same word.
    dq.push_back(mk(1'b0, 16'h0020, 16'h0000));
    dq.push_back(mk(1'b1, 16'h0020, 16'h5A5A));
    dq.push_back(mk(1'b0, 16'h0020, 16'h0000));
    run_until_empty(20);

    // Reset while three reads are in flight: all must be dropped.
    for (int k = 1; k < 4; k++) dq.push_back(mk(1'b0, 16'(k * 2), 16'h0000));
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (LAT + 4) step();
    for (int k = 0; k < 4; k++) dq.push_back(mk(1'b0, 16'(k * 2), 16'h0000));
    dq.push_back(mk(1'b0, 16'h0010, 16'h0000));
    run_until_empty(20);

    // Byte-lane bit ignored, top of array.
    dq.push_back(mk(1'b0, 16'h0001, 16'h0000));
    dq.push_back(mk(1'b0, 16'h0000, 16'h0000));
    iq.push_back(mk(1'b0, 16'hFFFF, 16'h0000));
    iq.push_back(mk(1'b0, 16'hFFFE, 16'h0000));
    run_until_empty(20);

    // Randomized traffic over the pool.
    rnd_mode = 1;
    for (int n = 0; n < 400; n++) begin
      if (dq.size() < 3 && $urandom_range(2) != 0)
        dq.push_back(mk(1'($urandom_range(2) == 0), pool_addr(), 16'($urandom)));
      if (iq.size() < 3 && $urandom_range(2) != 0)
        iq.push_back(mk(1'b0, pool_addr(), 16'h0000));
      step();
    end
    rnd_mode = 0;
    run_until_empty(100);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", expq.size());
    end
`ifdef MEM_STATS_EN
    checks++;
    if (rd_count !== 32'(rd_m) || wr_count !== 32'(wr_m) || i_stall_count !== 32'(st_m)) begin
      errors++;
      $display("FAIL stats: got rd=%0d wr=%0d stall=%0d, want rd=%0d wr=%0d stall=%0d",
               rd_count, wr_count, i_stall_count, rd_m, wr_m, st_m);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cache_mem_responder
`default_nettype wire
